// File: rtl/isolde_decoder_pkg.sv
// Shared ISOLDE decoder/exec types: opcodes, exec FSM states and the
// request payload bundle carried from decoder to functional unit.
package isolde_decoder_pkg;

  localparam int unsigned IMM32_OPS = 4;

  typedef enum logic [3:0] {
    ISOLDE_OP_INVALID,
    ISOLDE_OP_NOP,
    ISOLDE_OP_REDMULE,
    ISOLDE_OP_GEMM,
    ISOLDE_OP_CONV,
    ISOLDE_OP_LD,
    ISOLDE_OP_ST
  } isolde_opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } exec_state_e;

  typedef struct packed {
    isolde_opcode_e              opcode;
    logic [2:0]                  func3;
    logic [1:0]                  funct2;
    logic [31:0]                 instr;
    logic [IMM32_OPS*32-1:0]     imm32;
    logic [IMM32_OPS-1:0]        imm32_valid;
  } isolde_exec_payload_t;

endpackage

// File: rtl/isolde_exec_resp_if.sv
// Decoder-side req/gnt/dne handshake plus the functional-unit issue port.
// Signal suffixes are from the responder's point of view.
interface isolde_exec_resp_if;
  import isolde_decoder_pkg::*;

  logic                     isolde_exec_req_i;
  logic                     isolde_exec_gnt_o;
  logic                     isolde_exec_dne_o;
  logic                     isolde_exec_err_o;
  isolde_opcode_e           isolde_opcode_i;
  logic [2:0]               func3_i;
  logic [1:0]               funct2_i;
  logic [31:0]              isolde_decoder_instr_i;
  logic [IMM32_OPS*32-1:0]  isolde_decoder_imm32_i;
  logic [IMM32_OPS-1:0]     isolde_decoder_imm32_valid_i;
  logic                     unit_valid_o;
  logic                     unit_ready_i;
  isolde_opcode_e           unit_opcode_o;
  logic [2:0]               unit_func3_o;
  logic [1:0]               unit_funct2_o;
  logic [31:0]              unit_instr_o;
  logic [IMM32_OPS*32-1:0]  unit_imm32_o;
  logic [IMM32_OPS-1:0]     unit_imm32_valid_o;
  logic                     unit_done_i;
  logic                     busy_o;

  modport master (
    output isolde_exec_req_i, isolde_opcode_i,
    output func3_i, funct2_i,
    output isolde_decoder_instr_i,
    output isolde_decoder_imm32_i,
    output isolde_decoder_imm32_valid_i,
    output unit_ready_i, unit_done_i,
    input  isolde_exec_gnt_o, isolde_exec_dne_o,
    input  isolde_exec_err_o, unit_valid_o,
    input  unit_opcode_o, unit_func3_o,
    input  unit_funct2_o, unit_instr_o,
    input  unit_imm32_o, unit_imm32_valid_o,
    input  busy_o
  );

  modport slave (
    input  isolde_exec_req_i, isolde_opcode_i,
    input  func3_i, funct2_i,
    input  isolde_decoder_instr_i,
    input  isolde_decoder_imm32_i,
    input  isolde_decoder_imm32_valid_i,
    input  unit_ready_i, unit_done_i,
    output isolde_exec_gnt_o, isolde_exec_dne_o,
    output isolde_exec_err_o, unit_valid_o,
    output unit_opcode_o, unit_func3_o,
    output unit_funct2_o, unit_instr_o,
    output unit_imm32_o, unit_imm32_valid_o,
    output busy_o
  );

endinterface

// File: rtl/isolde_exec_pend_buf.sv
// One-entry payload holding register between decoder grant and issue.
// Push wins over pop so a same-cycle pop/push keeps the new entry.
module isolde_exec_pend_buf
  import isolde_decoder_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  isolde_exec_payload_t data_i,
  output isolde_exec_payload_t data_o,
  output logic                 valid_o
);

  logic                 valid_q, valid_d;
  isolde_exec_payload_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/isolde_exec_resp.sv
// Execute-side responder: buffers one decoded request, issues it to the
// functional unit, waits for done (or timeout) and pulses dne once.
module isolde_exec_resp
  import isolde_decoder_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               exec_rst_ni,
  isolde_exec_resp_if.slave  bus
);

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

  exec_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  isolde_exec_payload_t act_q, act_d;
  isolde_exec_payload_t req_pl, pend_pl;
  logic                 pend_valid, pend_pop, gnt;

  assign req_pl = '{
    opcode:      bus.isolde_opcode_i,
    func3:       bus.func3_i,
    funct2:      bus.funct2_i,
    instr:       bus.isolde_decoder_instr_i,
    imm32:       bus.isolde_decoder_imm32_i,
    imm32_valid: bus.isolde_decoder_imm32_valid_i
  };

  assign pend_pop = (state_q == IDLE) & pend_valid;
  // rst_ni gates gnt so every output is low during async reset
  assign gnt = bus.isolde_exec_req_i & rst_ni & exec_rst_ni
             & (~pend_valid | pend_pop);

  isolde_exec_pend_buf u_pend (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (~exec_rst_ni),
    .push_i  (gnt),
    .pop_i   (pend_pop),
    .data_i  (req_pl),
    .data_o  (pend_pl),
    .valid_o (pend_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: if (pend_pop) begin
        act_d   = pend_pl;
        state_d = ISSUE;
      end
      ISSUE: if (bus.unit_ready_i) begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.unit_done_i) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!exec_rst_ni) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      act_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      act_q   <= act_d;
    end
  end

  assign bus.isolde_exec_gnt_o  = gnt;
  assign bus.isolde_exec_dne_o  = (state_q == DONE);
  assign bus.isolde_exec_err_o  = (state_q == DONE) & err_q;
  assign bus.unit_valid_o       = (state_q == ISSUE);
  assign bus.unit_opcode_o      = act_q.opcode;
  assign bus.unit_func3_o       = act_q.func3;
  assign bus.unit_funct2_o      = act_q.funct2;
  assign bus.unit_instr_o       = act_q.instr;
  assign bus.unit_imm32_o       = act_q.imm32;
  assign bus.unit_imm32_valid_o = act_q.imm32_valid;
  assign bus.busy_o = pend_valid | (state_q != IDLE);

endmodule
